// File: rtl/l2cache_dirty_flush_ctrl.sv
// ---------------------------------------------------------------------------
// l2cache_dirty_flush_ctrl
//
// Arbitrates the single port of the L2 dirty table between the L2 main
// pipeline and a flush walker. On flush_req the walker visits every
// (set, way) entry in order. For each dirty entry it issues a writeback,
// waits for the writeback to commit, and then clears the dirty bit. The
// pipeline always has priority on the table port. While the pipeline holds
// the port, the walker stalls in the states that need it.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   flush_req                     start a full flush (accepted in IDLE only)
//   flush_busy / flush_done       walker active / one-cycle completion pulse
//   pipe_valid, pipe_addr,        pipeline access to the dirty table
//   pipe_way, pipe_set1,
//   pipe_set0, pipe_dirty
//   dt_addr, dt_way_select,       dirty table port (combinational read)
//   dt_set1, dt_set0, dt_dirty
//   wb_valid, wb_ready,           writeback request handshake and
//   wb_addr, wb_way, wb_done      completion
// ---------------------------------------------------------------------------
module l2cache_dirty_flush_ctrl #(
   parameter int addr_width = 4,
   parameter int way        = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_req,
   output logic                  flush_busy,
   output logic                  flush_done,
   input  logic                  pipe_valid,
   input  logic [addr_width-1:0] pipe_addr,
   input  logic [1:0]            pipe_way,
   input  logic                  pipe_set1,
   input  logic                  pipe_set0,
   output logic                  pipe_dirty,
   output logic [addr_width-1:0] dt_addr,
   output logic [1:0]            dt_way_select,
   output logic                  dt_set1,
   output logic                  dt_set0,
   input  logic                  dt_dirty,
   output logic                  wb_valid,
   input  logic                  wb_ready,
   output logic [addr_width-1:0] wb_addr,
   output logic [1:0]            wb_way,
   input  logic                  wb_done
);

   localparam int         CW       = addr_width + 2;
   localparam logic [1:0] LAST_WAY = 2'(way - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_WB_REQ,
      S_WB_WAIT,
      S_CLEAR,
      S_DONE
   } state_t;

   state_t                state_reg,   state_next;
   logic [CW-1:0]         cnt_reg,     cnt_next;
   logic                  redirty_reg, redirty_next;
   logic [addr_width-1:0] wb_addr_reg, wb_addr_next;
   logic [1:0]            wb_way_reg,  wb_way_next;

   logic [addr_width-1:0] cnt_set;
   logic [1:0]            cnt_way;
   logic                  cnt_last;
   logic [CW-1:0]         cnt_inc;
   logic                  redirty_hit;
   logic                  walker_set0;

   // The counter holds {set, way}. The way field wraps at way-1 rather than
   // at 3, so the walk stays correct when fewer than four ways are built.
   assign cnt_set  = cnt_reg[CW-1:2];
   assign cnt_way  = cnt_reg[1:0];
   assign cnt_last = (cnt_set == '1) && (cnt_way == LAST_WAY);
   assign cnt_inc  = (cnt_way == LAST_WAY) ? {cnt_set + addr_width'(1), 2'b00}
                                           : {cnt_set, cnt_way + 2'd1};

   // A pipeline store that hits the line being written back marks that line
   // dirty again. The final clear is then skipped so the new data is kept.
   assign redirty_hit = pipe_valid && pipe_set1 &&
                        (pipe_addr == wb_addr_reg) && (pipe_way == wb_way_reg);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= S_IDLE;
         cnt_reg     <= '0;
         redirty_reg <= 1'b0;
         wb_addr_reg <= '0;
         wb_way_reg  <= '0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         redirty_reg <= redirty_next;
         wb_addr_reg <= wb_addr_next;
         wb_way_reg  <= wb_way_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      redirty_next = redirty_reg;
      wb_addr_next = wb_addr_reg;
      wb_way_next  = wb_way_reg;

      case (state_reg)
         S_IDLE: begin
            if (flush_req) begin
               cnt_next   = '0;
               state_next = S_SCAN;
            end
         end
         S_SCAN: begin
            if (!pipe_valid) begin
               if (dt_dirty) begin
                  wb_addr_next = cnt_set;
                  wb_way_next  = cnt_way;
                  redirty_next = 1'b0;
                  state_next   = S_WB_REQ;
               end else if (cnt_last) begin
                  state_next = S_DONE;
               end else begin
                  cnt_next = cnt_inc;
               end
            end
         end
         S_WB_REQ: begin
            if (redirty_hit) redirty_next = 1'b1;
            if (wb_ready)    state_next   = S_WB_WAIT;
         end
         S_WB_WAIT: begin
            if (redirty_hit) redirty_next = 1'b1;
            if (wb_done)     state_next   = S_CLEAR;
         end
         S_CLEAR: begin
            if (redirty_hit) redirty_next = 1'b1;
            if (!pipe_valid) begin
               if (cnt_last) begin
                  state_next = S_DONE;
               end else begin
                  cnt_next   = cnt_inc;
                  state_next = S_SCAN;
               end
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // The walker only writes in CLEAR. The clear is suppressed when the
   // line was re-dirtied during its writeback.
   assign walker_set0 = (state_reg == S_CLEAR) && !redirty_reg;

   // Table port mux. The pipeline wins. Set1 wins over set0.
   assign dt_addr       = pipe_valid ? pipe_addr : cnt_set;
   assign dt_way_select = pipe_valid ? pipe_way  : cnt_way;
   assign dt_set1       = pipe_valid && pipe_set1;
   assign dt_set0       = pipe_valid ? (pipe_set0 && !pipe_set1) : walker_set0;
   assign pipe_dirty    = dt_dirty;

   assign flush_busy = (state_reg != S_IDLE) && (state_reg != S_DONE);
   assign flush_done = (state_reg == S_DONE);
   assign wb_valid   = (state_reg == S_WB_REQ);
   assign wb_addr    = wb_addr_reg;
   assign wb_way     = wb_way_reg;

endmodule

// File: tb/tb_l2cache_dirty_flush_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for l2cache_dirty_flush_ctrl (addr_width=4, way=4, 64 entries).
// The bench owns a behavioural dirty table that has a combinational read
// and is written one step after each clock edge. Expected writebacks come
// from a snapshot of that table taken before each flush. The snapshot gives
// the dirty entries in set*4+way order.
// ---------------------------------------------------------------------------
module tb_l2cache_dirty_flush_ctrl;

   logic       clk = 1'b0;
   logic       rst, flush_req, pipe_valid, pipe_set1, pipe_set0;
   logic [3:0] pipe_addr;
   logic [1:0] pipe_way;
   logic       wb_ready, wb_done;
   logic       flush_busy, flush_done, pipe_dirty;
   logic [3:0] dt_addr, wb_addr;
   logic [1:0] dt_way_select, wb_way;
   logic       dt_set1, dt_set0, dt_dirty, wb_valid;

   logic dirty_tbl [0:63];
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   assign dt_dirty = dirty_tbl[{dt_addr, dt_way_select}];

   l2cache_dirty_flush_ctrl #(.addr_width(4), .way(4)) dut (
      .clk(clk), .rst(rst),
      .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
      .pipe_valid(pipe_valid), .pipe_addr(pipe_addr), .pipe_way(pipe_way),
      .pipe_set1(pipe_set1), .pipe_set0(pipe_set0), .pipe_dirty(pipe_dirty),
      .dt_addr(dt_addr), .dt_way_select(dt_way_select),
      .dt_set1(dt_set1), .dt_set0(dt_set0), .dt_dirty(dt_dirty),
      .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_addr(wb_addr), .wb_way(wb_way), .wb_done(wb_done)
   );

   typedef struct {
      logic       pv;
      logic [3:0] addr;
      logic [1:0] wy;
      logic       s1, s0;
      logic       e_s1, e_s0, e_pd;
   } vec_t;
   vec_t vecs [9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end else begin
         $display("ok   %s: %0h", nm, act);
      end
   endtask

   // One clock: capture the table write request, take the edge, then commit it.
   task automatic cyc();
      logic s1, s0;
      logic [5:0] idx;
      #1;
      s1  = dt_set1;
      s0  = dt_set0;
      idx = {dt_addr, dt_way_select};
      @(posedge clk);
      #1;
      if (s1) dirty_tbl[idx] = 1'b1;
      else if (s0) dirty_tbl[idx] = 1'b0;
   endtask

   task automatic idle_inputs();
      flush_req = 0; pipe_valid = 0; pipe_addr = 0; pipe_way = 0;
      pipe_set1 = 0; pipe_set0 = 0; wb_ready = 0; wb_done = 0;
   endtask

   task automatic clear_tbl();
      for (int i = 0; i < 64; i++) dirty_tbl[i] = 1'b0;
   endtask

   function automatic int dirty_count();
      int n = 0;
      for (int i = 0; i < 64; i++) if (dirty_tbl[i]) n++;
      return n;
   endfunction

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      cyc(); cyc();
      rst = 0;
      #1;
      chk("reset_outs", {flush_busy, flush_done, wb_valid, dt_set1, dt_set0, wb_addr, wb_way},
          32'd0);
   endtask

   // A full flush with random stalls and random writeback timing. The
   // expected writeback order comes from a snapshot of the table.
   task automatic run_flush(input int stall_pct, input int ready_pct,
                            output int busy_n, output int done_n);
      int   exp_q[$];
      int   exp_e;
      bit   pending, prev_wait;
      int   dly;
      logic [5:0] prev_ent;
      for (int i = 0; i < 64; i++) if (dirty_tbl[i]) exp_q.push_back(i);
      busy_n = 0; done_n = 0; pending = 0; prev_wait = 0; dly = 0; prev_ent = 0;
      idle_inputs();
      flush_req = 1;
      cyc();
      flush_req = 0;
      for (int c = 0; c < 20000; c++) begin
         pipe_valid = ($urandom_range(99) < stall_pct);
         pipe_addr  = 4'($urandom_range(15));
         pipe_way   = 2'($urandom_range(3));
         wb_ready   = ($urandom_range(99) < ready_pct);
         if (pending && dly == 0) begin
            wb_done = 1; pending = 0;
         end else begin
            wb_done = !pending && ($urandom_range(9) == 0);
            if (pending) dly--;
         end
         #1;
         if (flush_done) begin
            done_n++;
            idle_inputs();
            cyc();
            #1;
            chk("done_pulse_end", {flush_done, flush_busy}, 32'd0);
            break;
         end
         if (flush_busy) busy_n++;
         if (pipe_valid)
            chk("mux_pipe", {dt_addr, dt_way_select, dt_set1, dt_set0},
                {pipe_addr, pipe_way, 2'b00});
         if (prev_wait)
            chk("wb_hold", {wb_valid, wb_addr, wb_way}, {1'b1, prev_ent});
         prev_wait = wb_valid && !wb_ready;
         prev_ent  = {wb_addr, wb_way};
         if (wb_valid && wb_ready) begin
            exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            chk("wb_entry", {26'd0, wb_addr, wb_way}, exp_e);
            pending = 1;
            dly = $urandom_range(3);
         end
         cyc();
      end
      chk("flush_done_count", done_n, 1);
      chk("wb_remaining", exp_q.size(), 0);
      idle_inputs();
   endtask

   // Runs the current sweep to completion, with the writeback path always ready.
   task automatic finish_sweep(output int busy_n, output int done_n, output int wb_n);
      busy_n = 0; done_n = 0; wb_n = 0;
      idle_inputs();
      wb_ready = 1; wb_done = 1;
      for (int c = 0; c < 1000; c++) begin
         #1;
         if (flush_done) begin
            done_n++;
            idle_inputs();
            cyc();
            #1;
            chk("done_pulse_end", {flush_done, flush_busy}, 32'd0);
            break;
         end
         if (flush_busy) busy_n++;
         if (wb_valid) wb_n++;
         cyc();
      end
      idle_inputs();
   endtask

   task automatic wait_wb(output bit ok);
      ok = 0;
      for (int c = 0; c < 300; c++) begin
         #1;
         if (wb_valid) begin ok = 1; break; end
         cyc();
      end
   endtask

   initial begin
      int  busy, done_n, wb_n, sc;
      bit  ok;

      vecs[0] = '{1'b1, 4'd3,  2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 4'd5,  2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 4'd9,  2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 4'd4,  2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 4'd15, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 4'd3,  2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{1'b1, 4'd9,  2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[7] = '{1'b1, 4'd9,  2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[8] = '{1'b1, 4'd3,  2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

      clear_tbl();
      do_reset();
      clear_tbl();

      // Port mux in IDLE, applied from the vector table.
      for (int i = 0; i < 9; i++) begin
         pipe_valid = vecs[i].pv; pipe_addr = vecs[i].addr; pipe_way = vecs[i].wy;
         pipe_set1 = vecs[i].s1; pipe_set0 = vecs[i].s0;
         #1;
         chk($sformatf("vec%0d_set", i), {dt_set1, dt_set0}, {vecs[i].e_s1, vecs[i].e_s0});
         if (vecs[i].pv) begin
            chk($sformatf("vec%0d_addr", i), {dt_addr, dt_way_select}, {vecs[i].addr, vecs[i].wy});
            chk($sformatf("vec%0d_pdirty", i), pipe_dirty, vecs[i].e_pd);
         end
         cyc();
      end
      idle_inputs();
      clear_tbl();

      // Empty table: 64 busy cycles, then done, no writeback.
      run_flush(0, 100, busy, done_n);
      chk("t1_busy_cycles", busy, 64);

      // Only (3,2) is dirty.
      dirty_tbl[14] = 1'b1;
      run_flush(0, 100, busy, done_n);
      chk("t2_tbl_clean", dirty_count(), 0);
      pipe_valid = 1; pipe_addr = 3; pipe_way = 2;
      #1;
      chk("t2_read_3_2", pipe_dirty, 0);
      cyc();
      idle_inputs();

      // Pipeline stall of 10 cycles in the middle of SCAN.
      flush_req = 1; cyc(); flush_req = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t3_scan_idx", {dt_addr, dt_way_select}, i);
         cyc();
      end
      for (int j = 0; j < 10; j++) begin
         pipe_valid = 1; pipe_addr = 4'(j + 2); pipe_way = 2'(j);
         #1;
         chk("t3_mux", {dt_addr, dt_way_select, dt_set1, dt_set0}, {4'(j + 2), 2'(j), 2'b00});
         cyc();
      end
      pipe_valid = 0;
      #1;
      chk("t3_resume_idx", {dt_addr, dt_way_select}, 5);
      finish_sweep(busy, done_n, wb_n);
      chk("t3_busy_total", busy + 15, 74);
      chk("t3_done", done_n, 1);

      // Pipeline store hits (5,1) during its writeback.
      clear_tbl();
      dirty_tbl[21] = 1'b1;
      flush_req = 1; cyc(); flush_req = 0;
      wait_wb(ok);
      chk("t4_wb_seen", ok, 1);
      chk("t4_wb_ent", {wb_addr, wb_way}, {4'd5, 2'd1});
      wb_ready = 1; cyc(); wb_ready = 0;
      pipe_valid = 1; pipe_addr = 5; pipe_way = 1; pipe_set1 = 1;
      #1;
      chk("t4_pipe_set1", dt_set1, 1);
      cyc();
      idle_inputs();
      wb_done = 1; cyc(); wb_done = 0;
      #1;
      chk("t4_clear_no_set0", {flush_busy, dt_set0, wb_valid}, 3'b100);
      finish_sweep(busy, done_n, wb_n);
      chk("t4_no_rewb", wb_n, 0);
      chk("t4_done", done_n, 1);
      pipe_valid = 1; pipe_addr = 5; pipe_way = 1;
      #1;
      chk("t4_read_5_1", pipe_dirty, 1);
      cyc();
      idle_inputs();

      // Reset while in WB_WAIT.
      clear_tbl();
      dirty_tbl[8] = 1'b1;
      flush_req = 1; cyc(); flush_req = 0;
      wait_wb(ok);
      chk("t5_wb_seen", ok, 1);
      wb_ready = 1; cyc(); wb_ready = 0;
      rst = 1; cyc(); rst = 0;
      #1;
      chk("t5_after_rst", {flush_busy, flush_done, wb_valid, wb_addr, wb_way}, 32'd0);
      sc = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (flush_done || flush_busy) sc++;
         cyc();
      end
      chk("t5_stays_idle", sc, 0);
      flush_req = 1; cyc(); flush_req = 0;
      #1;
      chk("t5_restart_idx", {flush_busy, dt_addr, dt_way_select}, {1'b1, 6'd0});
      rst = 1; cyc(); rst = 0;
      idle_inputs();

      // wb_ready held low for 20 cycles, with flush_req pulses.
      clear_tbl();
      dirty_tbl[31] = 1'b1;
      flush_req = 1; cyc(); flush_req = 0;
      wait_wb(ok);
      chk("t6_wb_seen", ok, 1);
      sc = 0;
      for (int i = 0; i < 20; i++) begin
         flush_req = (i % 3 == 0);
         #1;
         if (!(wb_valid && wb_addr == 4'd7 && wb_way == 2'd3 && flush_busy)) sc++;
         cyc();
      end
      chk("t6_wb_stable_bad_cycles", sc, 0);
      finish_sweep(busy, done_n, wb_n);
      chk("t6_wb_count", wb_n, 1);
      chk("t6_done", done_n, 1);
      cyc();
      #1;
      chk("t6_no_queued_flush", flush_busy, 0);

      // Randomized flushes with random stalls and writeback timing.
      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < 64; i++) dirty_tbl[i] = (it == 0) ? 1'($urandom_range(1))
                                                              : ($urandom_range(7) == 0);
         run_flush((it % 3) * 25, 30 + it * 14, busy, done_n);
         chk($sformatf("rnd%0d_tbl_clean", it), dirty_count(), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
